ysyx_24100012_mem_arbiter: RTL and testbench

//  Shares one memory port between the IFU (read-only) and the LSU (read/write) in the NPC.

---
 rtl/ysyx_24100012_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ysyx_24100012_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one memory port, one transaction in flight, with timeout error path.
// Latency: master handshake N -> mem_req_valid N+1; responses pass through combinationally; owner backpressure reaches memory.
module ysyx_24100012_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err,
    output logic                busy
);
    localparam int   MASK_W  = DATA_W / 8;
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_grant;
    logic                r_owner;
    logic [31:0]         r_timer;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    logic                w_grant_ifu;
    logic                w_grant_lsu;
    logic                w_owner_rdy;
    logic                w_timeout;
    logic                w_release;
    logic                w_rsp_vld;
    logic [DATA_W-1:0]   w_rsp_dat;
    logic                w_rsp_err;

    // On a tie the master that did not win last time goes first.
    assign w_grant_ifu = ifu_req_valid && (!lsu_req_valid || (r_last_grant == OWN_LSU));
    assign w_grant_lsu = lsu_req_valid && !w_grant_ifu;
    assign w_owner_rdy = (r_owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
    assign w_timeout   = (TIMEOUT_CYC != 0) && (r_timer == 32'(TIMEOUT_CYC - 1));

    always_comb begin
        w_next_state   = r_state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        w_rsp_vld      = 1'b0;
        w_rsp_dat      = '0;
        w_rsp_err      = 1'b0;
        w_release      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ifu_req_ready  = w_grant_ifu;
                lsu_req_ready  = w_grant_lsu;
                mem_resp_ready = 1'b1;
                if (w_grant_ifu || w_grant_lsu) w_next_state = S_REQ;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (w_timeout)          w_next_state = S_ERR;
                else if (mem_req_ready) w_next_state = S_RESP;
            end
            S_RESP: begin
                mem_resp_ready = w_owner_rdy;
                w_rsp_vld      = mem_resp_valid;
                w_rsp_dat      = mem_rdata;
                w_rsp_err      = mem_resp_err;
                // A completing response beats a simultaneous timeout.
                if (mem_resp_valid && w_owner_rdy) begin
                    w_release    = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_timeout) begin
                    w_next_state = S_ERR;
                end
            end
            S_ERR: begin
                mem_resp_ready = 1'b1;
                w_rsp_vld      = 1'b1;
                w_rsp_err      = 1'b1;
                if (w_owner_rdy) begin
                    w_release    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign ifu_resp_valid = (r_owner == OWN_IFU) && w_rsp_vld;
    assign ifu_rdata      = (r_owner == OWN_IFU) ? w_rsp_dat : '0;
    assign ifu_resp_err   = (r_owner == OWN_IFU) && w_rsp_err;
    assign lsu_resp_valid = (r_owner == OWN_LSU) && w_rsp_vld;
    assign lsu_rdata      = (r_owner == OWN_LSU) ? w_rsp_dat : '0;
    assign lsu_resp_err   = (r_owner == OWN_LSU) && w_rsp_err;

    assign mem_addr  = r_addr;
    assign mem_wen   = r_wen;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= OWN_LSU;
            r_owner      <= OWN_IFU;
            r_timer      <= '0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE) begin
                if (w_grant_ifu) begin
                    r_owner <= OWN_IFU;
                    r_addr  <= ifu_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                    r_wmask <= '0;
                    r_timer <= '0;
                end else if (w_grant_lsu) begin
                    r_owner <= OWN_LSU;
                    r_addr  <= lsu_addr;
                    r_wen   <= lsu_wen;
                    r_wdata <= lsu_wdata;
                    r_wmask <= lsu_wmask;
                    r_timer <= '0;
                end
            end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
                r_timer <= r_timer + 32'd1;
            end
            if (w_release) r_last_grant <= r_owner;
        end
    end
endmodule

// File: tb/tb_ysyx_24100012_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model of the arbiter.
module tb_ysyx_24100012_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;
    logic          busy;

    always #5 clk = ~clk;

    ysyx_24100012_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs;
        ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0; mem_resp_err = 0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        clr_inputs();
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    // Runs one transaction with instant memory; reports the granted master (0=IFU, 1=LSU).
    task automatic serve(output int who);
        logic [DW-1:0] d;
        who = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ifu_req_ready || lsu_req_ready) begin
                who = lsu_req_ready ? 1 : 0;
                break;
            end
            step();
        end
        if (who < 0) begin
            chk("serve_grant_timeout", 0, 1);
            return;
        end
        step();
        mem_req_ready = 1;
        #1;
        chk("serve_addr",  mem_addr,  (who == 1) ? lsu_addr : ifu_addr);
        chk("serve_wen",   mem_wen,   (who == 1) ? lsu_wen : 1'b0);
        chk("serve_wdata", mem_wdata, (who == 1) ? lsu_wdata : 32'h0);
        chk("serve_wmask", mem_wmask, (who == 1) ? lsu_wmask : 4'h0);
        step();
        mem_req_ready = 0;
        d = $urandom;
        mem_resp_valid = 1; mem_rdata = d; ifu_resp_ready = 1; lsu_resp_ready = 1;
        #1;
        chk("serve_rdata", (who == 1) ? lsu_rdata : ifu_rdata, d);
        step();
        mem_resp_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
    endtask

    // Random-phase model state
    bit            ip, iw, lp, lw, lwen, ir_prev, lr_prev;
    logic [AW-1:0] ia, la, ea;
    logic [DW-1:0] ld, ed, mrd;
    logic [MW-1:0] lm, em;
    bit            mb, mo, macc, mrv, ew, mre;
    int            rqd, rsd, ndone, mlast, who;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clr_inputs();

        // Reset state and first IFU read with minimum latency
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_ifu_rdy", ifu_req_ready, 0);
        chk("rst_lsu_rdy", lsu_req_ready, 0);
        chk("rst_mem_req_vld", mem_req_valid, 0);
        chk("rst_mem_resp_rdy", mem_resp_ready, 1);
        chk("rst_ifu_resp_vld", ifu_resp_valid, 0);
        chk("rst_lsu_resp_vld", lsu_resp_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #1;
        chk("t1_ifu_rdy", ifu_req_ready, 1);
        chk("t1_lsu_rdy", lsu_req_ready, 0);
        step();
        ifu_req_valid = 0; mem_req_ready = 1;
        #1;
        chk("t1_mem_req_vld", mem_req_valid, 1);
        chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk("t1_mem_wen", mem_wen, 0);
        chk("t1_mem_wmask", mem_wmask, 0);
        chk("t1_busy", busy, 1);
        chk("t1_ifu_rdy_busy", ifu_req_ready, 0);
        step();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0013; ifu_resp_ready = 1;
        #1;
        chk("t1_ifu_resp_vld", ifu_resp_valid, 1);
        chk("t1_ifu_rdata", ifu_rdata, 32'h13);
        chk("t1_ifu_err", ifu_resp_err, 0);
        chk("t1_mem_resp_rdy", mem_resp_ready, 1);
        chk("t1_lsu_resp_vld", lsu_resp_valid, 0);
        chk("t1_lsu_rdata", lsu_rdata, 0);
        step();
        mem_resp_valid = 0; ifu_resp_ready = 0;
        #1;
        chk("t1_idle", busy, 0);

        // Alternation under constant contention
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 1; lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'h3;
        for (int k = 0; k < 3; k++) begin
            serve(who);
            chk("t2_rr_order", who, k % 2);
        end
        clr_inputs();

        // LSU write payload
        lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        serve(who);
        chk("t3_lsu_granted", who, 1);
        clr_inputs();

        // Timeout while memory never accepts
        lsu_req_valid = 1; lsu_addr = 32'h8000_0300; lsu_wen = 0;
        #1;
        chk("t4_lsu_rdy", lsu_req_ready, 1);
        step();
        lsu_req_valid = 0;
        for (int i = 1; i <= TO; i++) begin
            #1;
            chk("t4_req_held", mem_req_valid, 1);
            chk("t4_no_resp", lsu_resp_valid, 0);
            step();
        end
        #1;
        chk("t4_err_req_vld", mem_req_valid, 0);
        chk("t4_err_resp_vld", lsu_resp_valid, 1);
        chk("t4_err_flag", lsu_resp_err, 1);
        chk("t4_err_rdata", lsu_rdata, 0);
        chk("t4_err_mem_rdy", mem_resp_ready, 1);
        chk("t4_err_ifu_vld", ifu_resp_valid, 0);
        chk("t4_err_busy", busy, 1);
        step();
        #1;
        chk("t4_err_hold", lsu_resp_valid, 1);
        lsu_resp_ready = 1;
        step();
        lsu_resp_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hBAD;
        #1;
        chk("t4_stray_busy", busy, 0);
        chk("t4_stray_drain", mem_resp_ready, 1);
        chk("t4_stray_lsu_vld", lsu_resp_valid, 0);
        chk("t4_stray_ifu_vld", ifu_resp_valid, 0);
        step();
        mem_resp_valid = 0;
        #1;
        chk("t4_after_busy", busy, 0);

        // Owner backpressure while memory response waits
        lsu_req_valid = 1; lsu_addr = 32'h8000_0400; lsu_wen = 0;
        step();
        lsu_req_valid = 0; mem_req_ready = 1;
        step();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234; lsu_resp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_mem_rdy_low", mem_resp_ready, 0);
            chk("t5_lsu_vld", lsu_resp_valid, 1);
            chk("t5_busy", busy, 1);
            step();
        end
        lsu_resp_ready = 1;
        #1;
        chk("t5_mem_rdy_high", mem_resp_ready, 1);
        chk("t5_rdata", lsu_rdata, 32'h1234);
        step();
        clr_inputs();
        #1;
        chk("t5_done", busy, 0);

        // Reset in the middle of a response phase
        ifu_req_valid = 1; ifu_addr = 32'h8000_0500;
        serve(who);
        chk("t6_ifu_first", who, 0);
        ifu_req_valid = 1;
        step();
        ifu_req_valid = 0; mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        #1;
        chk("t6_in_resp", busy, 1);
        mem_resp_valid = 1; ifu_resp_ready = 0; rst = 0;
        step();
        rst = 1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_ifu_vld", ifu_resp_valid, 0);
        chk("t6_lsu_vld", lsu_resp_valid, 0);
        chk("t6_drain", mem_resp_ready, 1);
        mem_resp_valid = 0; ifu_req_valid = 1; lsu_req_valid = 1;
        #1;
        chk("t6_last_lsu_ifu", ifu_req_ready, 1);
        chk("t6_last_lsu_lsu", lsu_req_ready, 0);
        ifu_req_valid = 0; lsu_req_valid = 0;

        // Randomized traffic against the transaction model
        ip = 0; iw = 0; lp = 0; lw = 0; lwen = 0; ir_prev = 1; lr_prev = 1;
        ia = '0; la = '0; ld = '0; lm = '0; ea = '0; ed = '0; em = '0; mrd = '0;
        mb = 0; mo = 0; macc = 0; mrv = 0; ew = 0; mre = 0;
        rqd = 0; rsd = 0; ndone = 0; mlast = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            ifu_req_valid = ip; ifu_addr = ia;
            lsu_req_valid = lp; lsu_addr = la; lsu_wen = lwen; lsu_wdata = ld; lsu_wmask = lm;
            mem_req_ready = 0;
            if (mb && !macc) begin
                mem_req_ready = (rqd == 0);
                if (rqd > 0) rqd--;
            end
            if (macc && !mrv) begin
                if (rsd == 0) mrv = 1;
                else rsd--;
            end
            mem_resp_valid = mrv;
            mem_rdata = mrv ? mrd : $urandom;
            mem_resp_err = mrv ? mre : 1'b0;
            ifu_resp_ready = ir_prev ? 1'($urandom_range(0, 1)) : 1'b1;
            lsu_resp_ready = lr_prev ? 1'($urandom_range(0, 1)) : 1'b1;
            ir_prev = ifu_resp_ready; lr_prev = lsu_resp_ready;
            #1;
            if (!mb) begin
                chk("r_ifu_rdy", ifu_req_ready, ip && (!lp || mlast == 1));
                chk("r_lsu_rdy", lsu_req_ready, lp && (!ip || mlast == 0));
                chk("r_idle_busy", busy, 0);
                chk("r_idle_req_vld", mem_req_valid, 0);
                chk("r_idle_drain", mem_resp_ready, 1);
                chk("r_idle_ifu_vld", ifu_resp_valid, 0);
                chk("r_idle_lsu_vld", lsu_resp_valid, 0);
            end else begin
                chk("r_busy_ifu_rdy", ifu_req_ready, 0);
                chk("r_busy_lsu_rdy", lsu_req_ready, 0);
                chk("r_busy", busy, 1);
                chk("r_req_vld", mem_req_valid, !macc);
                chk("r_other_rdata", mo ? ifu_rdata : lsu_rdata, 0);
                if (!macc) begin
                    chk("r_addr", mem_addr, ea);
                    chk("r_wen", mem_wen, ew);
                    chk("r_wdata", mem_wdata, ed);
                    chk("r_wmask", mem_wmask, em);
                end else begin
                    chk("r_own_vld", mo ? lsu_resp_valid : ifu_resp_valid, mrv);
                    chk("r_other_vld", mo ? ifu_resp_valid : lsu_resp_valid, 0);
                    chk("r_mem_rdy", mem_resp_ready, mo ? lsu_resp_ready : ifu_resp_ready);
                    if (mrv) begin
                        chk("r_rdata", mo ? lsu_rdata : ifu_rdata, mrd);
                        chk("r_err", mo ? lsu_resp_err : ifu_resp_err, mre);
                    end
                end
            end
            if (!mb) begin
                if (ifu_req_valid && ifu_req_ready) begin
                    mb = 1; mo = 0; ea = ia; ew = 0; ed = '0; em = '0; ip = 0; iw = 1;
                end else if (lsu_req_valid && lsu_req_ready) begin
                    mb = 1; mo = 1; ea = la; ew = lwen; ed = ld; em = lm; lp = 0; lw = 1;
                end
                if (mb) begin
                    macc = 0; mrv = 0; rqd = $urandom_range(0, 1);
                end
            end else if (!macc) begin
                if (mem_req_valid && mem_req_ready) begin
                    macc = 1; rsd = $urandom_range(0, 1); mrd = $urandom; mre = ($urandom_range(0, 7) == 0);
                end
            end else if (mrv && (mo ? lsu_resp_ready : ifu_resp_ready)) begin
                mb = 0; macc = 0; mrv = 0; mlast = mo; ndone++;
                if (mo) lw = 0;
                else iw = 0;
            end
            if (!ip && !iw && $urandom_range(0, 2) != 0) begin
                ip = 1; ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!lp && !lw && $urandom_range(0, 2) != 0) begin
                lp = 1; la = $urandom; lwen = 1'($urandom_range(0, 1)); ld = $urandom; lm = 4'($urandom_range(0, 15));
            end
        end
        chk("r_progress", ndone > 100, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
